// File: rtl/ws2812_pkg.sv
// Shared timing defaults (50 MHz clock) and FSM state type for the WS2812 serialiser.
package ws2812_pkg;

   localparam int DEF_BIT_CYC   = 63;
   localparam int DEF_T0H_CYC   = 20;
   localparam int DEF_T1H_CYC   = 40;
   localparam int DEF_RESET_CYC = 2600;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BIT   = 2'd1,
      LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/ws2812_tx_if.sv
// Frame bus between the LED frame generator and the WS2812 serialiser, plus strip line and debug state.
interface ws2812_tx_if
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 60
);
   // Handshake: start is sampled only while busy=0; an accepted start raises busy on the
   // same edge, busy stays high until the registered frame_done pulse, starts during busy are dropped.
   logic [NUM_LEDS*24-1:0] data;
   logic                   start;
   logic                   busy;
   logic                   frame_done;
   logic                   dout;
   state_t                 state;

   modport master (output data, start, input busy, frame_done, dout, state);
   modport slave  (input data, start, output busy, frame_done, dout, state);
endinterface

// File: rtl/ws2812_bit_encoder.sv
// One NRZ bit period: cycle counter plus registered dout (long high for 1, short high for 0).
module ws2812_bit_encoder
   import ws2812_pkg::*;
#(
   parameter int BIT_CYC = DEF_BIT_CYC,
   parameter int T0H_CYC = DEF_T0H_CYC,
   parameter int T1H_CYC = DEF_T1H_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic bit_active,
   input  logic bit_start,
   input  logic bit_val,
   output logic bit_last,
   output logic dout
);
   localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CW-1:0] LAST_L = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] T0H_L  = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H_L  = CW'(T1H_CYC);

   logic [CW-1:0] cyc_cnt;
   logic [CW-1:0] cyc_nxt;
   logic          dout_nxt;

   assign bit_last = bit_active && (cyc_cnt == LAST_L);

   // dout is computed from the next count so the registered line matches the count it sits beside
   always_comb begin
      cyc_nxt  = '0;
      dout_nxt = 1'b0;
      if (bit_start) begin
         cyc_nxt  = '0;
         dout_nxt = 1'b1;
      end else if (bit_active && !bit_last) begin
         cyc_nxt  = cyc_cnt + 1'b1;
         dout_nxt = (cyc_nxt < (bit_val ? T1H_L : T0H_L));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt <= '0;
         dout    <= 1'b0;
      end else begin
         cyc_cnt <= cyc_nxt;
         dout    <= dout_nxt;
      end
   end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 frame serialiser: shadows a NUM_LEDS*24-bit frame, sends it MSB first, then holds the latch gap.
module ws2812_tx
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS  = 60,
   parameter int BIT_CYC   = DEF_BIT_CYC,
   parameter int T0H_CYC   = DEF_T0H_CYC,
   parameter int T1H_CYC   = DEF_T1H_CYC,
   parameter int RESET_CYC = DEF_RESET_CYC
) (
   input  logic       clk,
   input  logic       reset,
   ws2812_tx_if.slave bus
);
   localparam int FW = NUM_LEDS * 24;
   localparam int BW = (FW > 1) ? $clog2(FW) : 1;
   localparam int RW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

   if (!(NUM_LEDS >= 1 && T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC >= 1))
   begin : g_param_check
      $error("ws2812_tx: illegal timing parameters");
   end

   state_t        state, state_nxt;
   logic [FW-1:0] shadow, shadow_nxt;
   logic [BW-1:0] bit_cnt, bit_cnt_nxt;
   logic [RW-1:0] gap_cnt, gap_cnt_nxt;
   logic          busy_q, busy_nxt;
   logic          done_q, done_nxt;
   logic          bit_start, bit_last;

   always_comb begin
      state_nxt   = state;
      shadow_nxt  = shadow;
      bit_cnt_nxt = bit_cnt;
      gap_cnt_nxt = gap_cnt;
      busy_nxt    = busy_q;
      done_nxt    = 1'b0;
      bit_start   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt   = BIT;
               shadow_nxt  = bus.data;
               bit_cnt_nxt = BW'(FW - 1);
               busy_nxt    = 1'b1;
               bit_start   = 1'b1;
            end
         end
         BIT: begin
            if (bit_last) begin
               if (bit_cnt == '0) begin
                  state_nxt   = LATCH;
                  gap_cnt_nxt = '0;
               end else begin
                  shadow_nxt  = shadow << 1;
                  bit_cnt_nxt = bit_cnt - 1'b1;
                  bit_start   = 1'b1;
               end
            end
         end
         LATCH: begin
            if (gap_cnt == RW'(RESET_CYC - 1)) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shadow  <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shadow  <= shadow_nxt;
         bit_cnt <= bit_cnt_nxt;
         gap_cnt <= gap_cnt_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
      end
   end

   ws2812_bit_encoder #(
      .BIT_CYC (BIT_CYC),
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC)
   ) u_enc (
      .clk        (clk),
      .reset      (reset),
      .bit_active (state == BIT),
      .bit_start  (bit_start),
      .bit_val    (shadow[FW-1]),
      .bit_last   (bit_last),
      .dout       (bus.dout)
   );

   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
   assign bus.state      = state;

endmodule

// File: tb/tb_ws2812_tx.sv
// Scoreboard bench for ws2812_tx: expected pulse widths and frame timings are queued at stimulus time.
module tb_ws2812_tx;
   import ws2812_pkg::*;

   localparam int NUM_LEDS  = 2;
   localparam int BIT_CYC   = 10;
   localparam int T0H_CYC   = 3;
   localparam int T1H_CYC   = 6;
   localparam int RESET_CYC = 20;
   localparam int FW        = 48;
   localparam int FRAME_CYC = 500;   // 48 bits * 10 cycles + 20 gap cycles

   typedef struct packed {
      logic [15:0] busy_len;
      logic [15:0] tail_len;
   } frame_exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] exp_q[$];
   frame_exp_t frm_q[$];

   ws2812_tx_if #(.NUM_LEDS(NUM_LEDS)) bus();

   ws2812_tx #(
      .NUM_LEDS  (NUM_LEDS),
      .BIT_CYC   (BIT_CYC),
      .T0H_CYC   (T0H_CYC),
      .T1H_CYC   (T1H_CYC),
      .RESET_CYC (RESET_CYC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // high widths: 6 cycles for a 1 bit, 3 for a 0; tail = last bit low part + 20-cycle gap
   task automatic push_frame(input logic [47:0] d);
      frame_exp_t f;
      for (int i = FW - 1; i >= 0; i--) exp_q.push_back(d[i] ? 8'd6 : 8'd3);
      f.busy_len = 16'(FRAME_CYC);
      f.tail_len = d[0] ? 16'd24 : 16'd27;
      frm_q.push_back(f);
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_pulse();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!bus.frame_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_seen", bus.frame_done, 1);
   endtask

   // ---------------- pulse monitor ----------------
   logic prev_dout = 1'b0;
   int   hi_cnt = 0;
   int   since_rise = 0;
   bit   have_rise = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         prev_dout  = 1'b0;
         hi_cnt     = 0;
         since_rise = 0;
         have_rise  = 1'b0;
      end else begin
         since_rise++;
         if (bus.dout && !prev_dout) begin
            if (have_rise) check("bit_period", since_rise, BIT_CYC);
            have_rise  = 1'b1;
            since_rise = 0;
            hi_cnt     = 0;
         end
         if (bus.dout) hi_cnt++;
         if (!bus.dout && prev_dout) begin
            if (exp_q.size() == 0) check("unexpected_pulse", hi_cnt, 0);
            else check("pulse_high", hi_cnt, exp_q.pop_front());
         end
         if (bus.frame_done) have_rise = 1'b0;
         prev_dout = bus.dout;
      end
   end

   // ---------------- frame monitor ----------------
   int         busy_cnt = 0;
   int         low_cnt  = 0;
   frame_exp_t cur_f;

   always @(negedge clk) begin
      if (reset) begin
         busy_cnt = 0;
         low_cnt  = 0;
      end else begin
         if (bus.frame_done) begin
            check("done_busy_low", bus.busy, 0);
            if (frm_q.size() == 0) check("unexpected_frame_done", busy_cnt, 0);
            else begin
               cur_f = frm_q.pop_front();
               check("busy_len", busy_cnt, cur_f.busy_len);
               check("latch_tail", low_cnt, cur_f.tail_len);
            end
            busy_cnt = 0;
         end
         if (bus.busy) busy_cnt++;
         if (bus.dout) low_cnt = 0;
         else low_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   int n;

   initial begin
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.data  = '0;

      // reset mid-cycle with start held high
      #2 reset = 1'b1;
      bus.start = 1'b1;
      #1;
      check("rst_dout", bus.dout, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.frame_done, 0);
      check("rst_state", bus.state, IDLE);
      repeat (5) @(negedge clk);
      check("rst_start_ignored_busy", bus.busy, 0);
      check("rst_start_ignored_dout", bus.dout, 0);
      bus.start = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_state", bus.state, IDLE);

      // single frame, shadow and ignore rules
      bus.data = 48'hFF0000_000000;
      push_frame(48'hFF0000_000000);
      start_pulse();
      repeat (98) @(posedge clk);
      #1 bus.data = {48{1'b1}};
      start_pulse();
      wait_done(600, n);
      repeat (600) @(negedge clk);
      check("no_second_frame_busy", bus.busy, 0);
      check("no_second_frame_state", bus.state, IDLE);

      // back-to-back with start held high
      bus.data = 48'h123456_ABCDEF;
      push_frame(48'h123456_ABCDEF);
      push_frame(48'h123456_ABCDEF);
      @(posedge clk); #1 bus.start = 1'b1;
      wait_done(600, n);
      @(negedge clk);
      check("b2b_first_rise_dout", bus.dout, 1);
      check("b2b_first_rise_busy", bus.busy, 1);
      bus.start = 1'b0;
      wait_done(600, n);
      check("b2b_done_spacing", n + 1, FRAME_CYC + 1);
      repeat (50) @(negedge clk);

      // abort at bit 17, then recover
      bus.data = 48'hF0F0F0_0F0F0F;
      push_frame(48'hF0F0F0_0F0F0F);
      start_pulse();
      repeat (170) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_dout", bus.dout, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.frame_done, 0);
      exp_q.delete();
      frm_q.delete();
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_no_done_state", bus.state, IDLE);
      bus.data = 48'h5A5A5A_A5A5A5;
      push_frame(48'h5A5A5A_A5A5A5);
      start_pulse();
      wait_done(600, n);
      repeat (5) @(negedge clk);

      // extremes
      bus.data = 48'h0;
      push_frame(48'h0);
      start_pulse();
      wait_done(600, n);
      repeat (5) @(negedge clk);
      bus.data = {48{1'b1}};
      push_frame({48{1'b1}});
      start_pulse();
      wait_done(600, n);
      repeat (40) @(negedge clk);

      check("pulse_queue_empty", exp_q.size(), 0);
      check("frame_queue_empty", frm_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
